// File: rtl/fetch_stage_pkg.sv
// Shared constants, F/D payload type and fetch legality helper for the fetch stage.
package fetch_stage_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 32;

    localparam logic [ADDR_W-1:0] RESET_PC  = 32'h0000_3000;
    localparam logic [ADDR_W-1:0] IM_BASE   = 32'h0000_3000;
    localparam logic [ADDR_W-1:0] IM_LIMIT  = 32'h0000_6FFC;
    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

    // Contents of the F/D pipeline register.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic              valid;
        logic              exc_adel;
    } fd_payload_t;

    // Word-aligned and inside the instruction memory window (unsigned, inclusive).
    function automatic logic fetch_ok(input logic [ADDR_W-1:0] pc);
        return (pc[1:0] == 2'b00) && (pc >= IM_BASE) && (pc <= IM_LIMIT);
    endfunction

endpackage

// File: rtl/fetch_stage_fd_reg.sv
// F/D pipeline register: reset > flush > stall > normal load.
module fetch_stage_fd_reg
    import fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush_d,
    input  logic [ADDR_W-1:0] f_pc,
    input  logic [DATA_W-1:0] f_instr,
    input  logic              f_ok,
    output fd_payload_t       fd_q
);

    // Flush inserts a bubble tagged with the current fetch PC even while stalled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fd_q <= '{pc: RESET_PC, instr: NOP_INSTR, valid: 1'b0, exc_adel: 1'b0};
        end else if (flush_d) begin
            fd_q <= '{pc: f_pc, instr: NOP_INSTR, valid: 1'b0, exc_adel: 1'b0};
        end else if (!stall) begin
            fd_q <= '{pc: f_pc,
                      instr: f_ok ? f_instr : NOP_INSTR,
                      valid: 1'b1,
                      exc_adel: !f_ok};
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, fetch legality, F/D register and activity counters.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] npc,
    input  logic              stall,
    input  logic              flush_d,
    input  logic [DATA_W-1:0] im_rdata,
    output logic [ADDR_W-1:0] im_addr,
    output logic [ADDR_W-1:0] I_pc,
    output logic [ADDR_W-1:0] D_pc,
    output logic [DATA_W-1:0] D_instr,
    output logic              D_valid,
    output logic              D_exc_adel,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic        f_ok;
    fd_payload_t fd_q;

    assign f_ok    = fetch_ok(I_pc);
    assign im_addr = I_pc;

    // PC follows npc unless stalled; faulted fetches do not stop it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            I_pc <= RESET_PC;
        end else if (!stall) begin
            I_pc <= npc;
        end
    end

    // Counters wrap naturally; fetch_cnt only counts legal normal loads.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (!stall && !flush_d && f_ok) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
        end
    end

    fetch_stage_fd_reg u_fd_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .stall   (stall),
        .flush_d (flush_d),
        .f_pc    (I_pc),
        .f_instr (im_rdata),
        .f_ok    (f_ok),
        .fd_q    (fd_q)
    );

    assign D_pc       = fd_q.pc;
    assign D_instr    = fd_q.instr;
    assign D_valid    = fd_q.valid;
    assign D_exc_adel = fd_q.exc_adel;

endmodule
